// File: rtl/fetch_stage_if.sv
// Bundle of the signals between the fetch stage, instruction memory,
// hazard/branch logic and the decode stage.
interface fetch_stage_if;
  logic [15:0] instr;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        interruptReq;
  logic [31:0] pc;
  logic [15:0] instrF2D;
  logic [31:0] pcF2D;
  logic        validF2D;
  logic [31:0] retPC;
  logic        intAck;
  logic        busy;

  modport master (
    input  instr, stall, branchTaken, branchTarget, interruptReq,
    output pc, instrF2D, pcF2D, validF2D, retPC, intAck, busy
  );

  modport slave (
    output instr, stall, branchTaken, branchTarget, interruptReq,
    input  pc, instrF2D, pcF2D, validF2D, retPC, intAck, busy
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, loads it from the reset/interrupt
// vectors in instruction memory, and fills the F/D pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'd0,
  parameter logic [31:0] INT_VEC   = 32'd2,
  parameter logic [15:0] NOP_WORD  = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {VEC_HI, VEC_LO, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] pcHigh_q, pcHigh_d;
  logic        intPending_q, intPending_d;
  logic        intFetch_q, intFetch_d;
  logic [15:0] instrF2D_q, instrF2D_d;
  logic [31:0] pcF2D_q, pcF2D_d;
  logic        validF2D_q, validF2D_d;
  logic [31:0] retPC_q, retPC_d;
  logic        intAck_q, intAck_d;
  logic        intAccept;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pcHigh_d   = pcHigh_q;
    intFetch_d = intFetch_q;
    instrF2D_d = instrF2D_q;
    pcF2D_d    = pcF2D_q;
    validF2D_d = validF2D_q;
    retPC_d    = retPC_q;
    intAck_d   = 1'b0;
    intAccept  = 1'b0;

    case (state_q)
      VEC_HI: begin
        pcHigh_d   = bus.instr;
        pc_d       = pc_q + 32'd1;
        state_d    = VEC_LO;
        instrF2D_d = NOP_WORD;
        validF2D_d = 1'b0;
        // A branch resolving while the handler vector loads redirects the return point.
        if (intFetch_q && bus.branchTaken) retPC_d = bus.branchTarget;
      end
      VEC_LO: begin
        pc_d       = {pcHigh_q, bus.instr};
        state_d    = RUN;
        intFetch_d = 1'b0;
        instrF2D_d = NOP_WORD;
        validF2D_d = 1'b0;
        if (intFetch_q && bus.branchTaken) retPC_d = bus.branchTarget;
      end
      default: begin
        if (bus.branchTaken) begin
          pc_d       = bus.branchTarget;
          instrF2D_d = NOP_WORD;
          validF2D_d = 1'b0;
        end else if (intPending_q && !bus.stall) begin
          intAccept  = 1'b1;
          retPC_d    = pc_q;
          intAck_d   = 1'b1;
          intFetch_d = 1'b1;
          pc_d       = INT_VEC;
          state_d    = VEC_HI;
          instrF2D_d = NOP_WORD;
          validF2D_d = 1'b0;
        end else if (!bus.stall) begin
          instrF2D_d = bus.instr;
          pcF2D_d    = pc_q;
          validF2D_d = 1'b1;
          pc_d       = pc_q + 32'd1;
        end
      end
    endcase

    // Requests seen on the accepting edge are folded into the accepted one.
    if (intAccept)             intPending_d = 1'b0;
    else if (bus.interruptReq) intPending_d = 1'b1;
    else                       intPending_d = intPending_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= VEC_HI;
      pc_q         <= RESET_VEC;
      pcHigh_q     <= 16'h0000;
      intPending_q <= 1'b0;
      intFetch_q   <= 1'b0;
      instrF2D_q   <= NOP_WORD;
      pcF2D_q      <= 32'd0;
      validF2D_q   <= 1'b0;
      retPC_q      <= 32'd0;
      intAck_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pcHigh_q     <= pcHigh_d;
      intPending_q <= intPending_d;
      intFetch_q   <= intFetch_d;
      instrF2D_q   <= instrF2D_d;
      pcF2D_q      <= pcF2D_d;
      validF2D_q   <= validF2D_d;
      retPC_q      <= retPC_d;
      intAck_q     <= intAck_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.instrF2D = instrF2D_q;
  assign bus.pcF2D    = pcF2D_q;
  assign bus.validF2D = validF2D_q;
  assign bus.retPC    = retPC_q;
  assign bus.intAck   = intAck_q;
  assign bus.busy     = (state_q != RUN);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap-around sequence, then
// randomized traffic checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic clk;
  logic reset;
  fetch_stage_if bus();

  logic [15:0] imem [0:255];
  int total = 0;
  int bad   = 0;

  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus.master));

  assign bus.instr = imem[bus.pc[7:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  ctl;     // {reset, stall, branchTaken, interruptReq}
    logic [31:0] tgt;
    logic [31:0] ePc;
    logic [15:0] eInstr;
    logic [31:0] ePcF2D;
    logic [2:0]  eFlags;  // {validF2D, intAck, busy}
    logic [31:0] eRet;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: vecLeft counts vector half-words still to load.
  int          mVecLeft;
  logic [31:0] mPc, mPcF2D, mRet;
  logic [15:0] mHigh, mInstr;
  logic        mValid, mAck, mPending, mIntFetch;

  function automatic vec_t mk(logic [3:0] ctl, logic [31:0] tgt, logic [31:0] ePc,
                              logic [15:0] eInstr, logic [31:0] ePcF2D,
                              logic [2:0] eFlags, logic [31:0] eRet);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.ePc = ePc; v.eInstr = eInstr;
    v.ePcF2D = ePcF2D; v.eFlags = eFlags; v.eRet = eRet;
    return v;
  endfunction

  task automatic applyStimulus(logic rst, logic stl, logic br, logic [31:0] tgt, logic irq);
    reset            = rst;
    bus.stall        = stl;
    bus.branchTaken  = br;
    bus.branchTarget = tgt;
    bus.interruptReq = irq;
  endtask

  task automatic checkOne(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] ePc, logic [15:0] eInstr,
                             logic [31:0] ePcF2D, logic eValid, logic eAck,
                             logic eBusy, logic [31:0] eRet);
    checkOne({tag, " pc"},       bus.pc, ePc);
    checkOne({tag, " instrF2D"}, {16'h0, bus.instrF2D}, {16'h0, eInstr});
    checkOne({tag, " pcF2D"},    bus.pcF2D, ePcF2D);
    checkOne({tag, " validF2D"}, {31'h0, bus.validF2D}, {31'h0, eValid});
    checkOne({tag, " intAck"},   {31'h0, bus.intAck}, {31'h0, eAck});
    checkOne({tag, " busy"},     {31'h0, bus.busy}, {31'h0, eBusy});
    checkOne({tag, " retPC"},    bus.retPC, eRet);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    mInstr = 16'h0000;
    mValid = 1'b0;
  endtask

  // Advance the model by one edge from the inputs currently applied.
  task automatic modelEdge();
    logic [15:0] w;
    logic        take;
    w    = imem[mPc[7:0]];
    take = 1'b0;
    mAck = 1'b0;
    if (reset) begin
      mPc = 32'd0; mVecLeft = 2; mIntFetch = 1'b0; mPending = 1'b0;
      mInstr = 16'h0000; mPcF2D = 32'd0; mValid = 1'b0; mRet = 32'd0;
      return;
    end
    if (mVecLeft > 0) begin
      if (mIntFetch && bus.branchTaken) mRet = bus.branchTarget;
      if (mVecLeft == 2) begin
        mHigh = w;
        mPc   = mPc + 32'd1;
      end else begin
        mPc       = {mHigh, w};
        mIntFetch = 1'b0;
      end
      mVecLeft = mVecLeft - 1;
      bubble();
    end else if (bus.branchTaken) begin
      mPc = bus.branchTarget;
      bubble();
    end else if (mPending && !bus.stall) begin
      take      = 1'b1;
      mRet      = mPc;
      mAck      = 1'b1;
      mIntFetch = 1'b1;
      mPc       = 32'd2;
      mVecLeft  = 2;
      bubble();
    end else if (!bus.stall) begin
      mInstr = w;
      mPcF2D = mPc;
      mValid = 1'b1;
      mPc    = mPc + 32'd1;
    end
    if (take) mPending = 1'b0;
    else if (bus.interruptReq) mPending = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 256; i++) imem[i] = 16'hA000 | 16'(i);
    imem[0] = 16'h0000; imem[1] = 16'h0010;
    imem[2] = 16'h0000; imem[3] = 16'h0080;

    vecs.push_back(mk(4'b1000, 32'h0,  32'h0,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b1000, 32'h0,  32'h0,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h1,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h10, 16'h0000, 32'h0,  3'b000, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h11, 16'hA010, 32'h10, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h12, 16'hA011, 32'h11, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0100, 32'h0,  32'h12, 16'hA011, 32'h11, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0100, 32'h0,  32'h12, 16'hA011, 32'h11, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h13, 16'hA012, 32'h12, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0110, 32'h40, 32'h40, 16'h0000, 32'h12, 3'b000, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h41, 16'hA040, 32'h40, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h42, 16'hA041, 32'h41, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0001, 32'h0,  32'h43, 16'hA042, 32'h42, 3'b100, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h2,  16'h0000, 32'h42, 3'b011, 32'h43));
    vecs.push_back(mk(4'b0001, 32'h0,  32'h3,  16'h0000, 32'h42, 3'b001, 32'h43));
    vecs.push_back(mk(4'b0010, 32'h55, 32'h80, 16'h0000, 32'h42, 3'b000, 32'h55));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h2,  16'h0000, 32'h42, 3'b011, 32'h80));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h3,  16'h0000, 32'h42, 3'b001, 32'h80));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h80, 16'h0000, 32'h42, 3'b000, 32'h80));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h81, 16'hA080, 32'h80, 3'b100, 32'h80));
    vecs.push_back(mk(4'b1000, 32'h0,  32'h0,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h1,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b1000, 32'h0,  32'h0,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h1,  16'h0000, 32'h0,  3'b001, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h10, 16'h0000, 32'h0,  3'b000, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0,  32'h11, 16'hA010, 32'h10, 3'b100, 32'h0));

    $display("[TB] directed vector table, %0d rows", vecs.size());
    foreach (vecs[r]) begin
      applyStimulus(vecs[r].ctl[3], vecs[r].ctl[2], vecs[r].ctl[1], vecs[r].tgt, vecs[r].ctl[0]);
      tick();
      checkOutput($sformatf("row%0d", r), vecs[r].ePc, vecs[r].eInstr, vecs[r].ePcF2D,
                  vecs[r].eFlags[2], vecs[r].eFlags[1], vecs[r].eFlags[0], vecs[r].eRet);
    end

    $display("[TB] wrap-around vector");
    imem[0] = 16'hFFFF; imem[1] = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrapHi", 32'h1, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    checkOutput("wrapLo", 32'hFFFF_FFFF, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wrapRun", 32'h0, 16'hA0FF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] randomized traffic against model");
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(c < 2 || $urandom_range(0, 79) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom,
                    $urandom_range(0, 11) == 0);
      modelEdge();
      tick();
      checkOutput($sformatf("rand%0d", c), mPc, mInstr, mPcF2D, mValid, mAck,
                  mVecLeft != 0, mRet);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
